ex_mem_skid: RTL

Pipeline boundary between the execute stage and the memory stage of the processor datapath. It captures the ALU result, store data and memory/write-back control from execute and presents them, registered, to the memory stage. It uses a two-entry skid buffer so the memory stage can stall (`out_ready` low) without combinational back-pressure into execute. It also supports a synchronous pipeline flush and keeps a saturating count of memory-stage stall cycles.

---
 rtl/ex_mem_skid.sv | 111 +++++++++++
 1 files changed

// File: rtl/ex_mem_skid.sv
// Execute-to-memory pipeline boundary: a two-slot skid buffer with registered ready,
// synchronous flush and a saturating memory-stage stall counter.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_data2,
    input  logic              in_we,
    input  logic              in_select_mem,
    input  logic              in_reg_write,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_data2,
    output logic              out_we,
    output logic              out_select_mem,
    output logic              out_reg_write,
    output logic [REG_W-1:0]  out_rd,
    output logic [CNT_W-1:0]  stall_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              main_vld, skid_vld;
    logic [DATA_W-1:0] main_alu, main_d2, skid_alu, skid_d2;
    logic              main_we, main_sel, main_rw;
    logic              skid_we, skid_sel, skid_rw;
    logic [REG_W-1:0]  main_rd, skid_rd;
    logic              in_fire, out_fire;

    // in_ready is a direct copy of a flop, so execute never sees out_ready combinationally.
    assign in_ready = ~skid_vld;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_vld & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_alu <= '0;
            main_d2  <= '0;
            main_we  <= 1'b0;
            main_sel <= 1'b0;
            main_rw  <= 1'b0;
            main_rd  <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || (!skid_vld && out_fire)) begin
            // EMPTY, or ONE draining: the input (if any) goes straight to main.
            main_vld <= in_fire;
            if (in_fire) begin
                main_alu <= in_alu_result;
                main_d2  <= in_data2;
                main_we  <= in_we;
                main_sel <= in_select_mem;
                main_rw  <= in_reg_write;
                main_rd  <= in_rd;
            end
        end else if (!skid_vld) begin
            skid_vld <= in_fire;
        end else if (out_fire) begin
            main_alu <= skid_alu;
            main_d2  <= skid_d2;
            main_we  <= skid_we;
            main_sel <= skid_sel;
            main_rw  <= skid_rw;
            main_rd  <= skid_rd;
            skid_vld <= 1'b0;
        end
    end

    // Skid payload is only meaningful while skid_vld is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_fire && main_vld && !out_fire) begin
            skid_alu <= in_alu_result;
            skid_d2  <= in_data2;
            skid_we  <= in_we;
            skid_sel <= in_select_mem;
            skid_rw  <= in_reg_write;
            skid_rd  <= in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (main_vld && !out_ready) begin
            stall_count <= sat_inc(stall_count);
        end
    end

    assign out_valid      = main_vld;
    assign out_alu_result = main_alu;
    assign out_data2      = main_d2;
    assign out_select_mem = main_sel;
    assign out_rd         = main_rd;
    assign out_we         = main_we & main_vld;
    assign out_reg_write  = main_rw & main_vld;

endmodule
